// File: rtl/uart_load_ctrl_pkg.sv
// Shared types and constants for the UART boot-load controller.
package uart_load_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } load_state_t;

  localparam int          LOAD_LEN_BYTES = 4;
  localparam logic [31:0] ADDR_STRIDE    = 32'd4;

endpackage

// File: rtl/uart_load_ctrl.sv
// Assembles the UART byte stream into little-endian words and writes them
// to memory port B, then raises uart_finish to release the core.
//
// state | meaning
// IDLE  | waiting for the first length byte of a frame
// LEN   | collecting length bytes 1..3
// DATA  | assembling payload words and issuing writes
// DONE  | load complete, input ignored until rst
module uart_load_ctrl
  import uart_load_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 16384,
  parameter int          TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [31:0] uart_addr,
  output logic [31:0] uart_data,
  output logic        uart_we,
  output logic        uart_finish,
  output logic        load_err,
  output logic        busy
);

  localparam int         TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST_IDX = 2'(LOAD_LEN_BYTES - 1);

  load_state_t       state, state_nxt;
  logic [23:0]       shift;
  logic [1:0]        byte_idx;
  logic [31:0]       n_words;
  logic [31:0]       word_cnt;
  logic [31:0]       next_addr;
  logic [TMR_W-1:0]  tmr;

  logic [31:0]       word;
  logic              active;
  logic              timeout;
  logic              accept;
  logic              last_byte;
  logic              last_write;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word       = {rx_byte, shift};
    active     = (state == LEN) || (state == DATA);
    // The idle timer is judged on its registered value, so a byte that
    // lands in the expiry cycle loses to the timeout.
    timeout    = active && (tmr == '0);
    accept     = rx_valid && !timeout && (state != DONE);
    last_byte  = accept && (byte_idx == LAST_IDX);
    last_write = uart_we && (word_cnt + 32'd1 == n_words);
    case (state)
      IDLE: if (accept) state_nxt = LEN;
      LEN: begin
        if (timeout) state_nxt = IDLE;
        else if (last_byte) begin
          if (word == 32'd0)                 state_nxt = DONE;
          else if (word > 32'(MAX_WORDS))    state_nxt = IDLE;
          else                               state_nxt = DATA;
        end
      end
      DATA: begin
        if (timeout)         state_nxt = IDLE;
        else if (last_write) state_nxt = DONE;
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift       <= '0;
      byte_idx    <= '0;
      n_words     <= '0;
      word_cnt    <= '0;
      next_addr   <= BASE_ADDR;
      tmr         <= '0;
      uart_addr   <= BASE_ADDR;
      uart_data   <= '0;
      uart_we     <= 1'b0;
      uart_finish <= 1'b0;
      load_err    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      uart_we     <= 1'b0;
      busy        <= (state_nxt == LEN) || (state_nxt == DATA);
      uart_finish <= (state_nxt == DONE);

      if (accept) begin
        shift    <= word[31:8];
        byte_idx <= byte_idx + 2'd1;
      end
      if (timeout) begin
        byte_idx <= '0;
        load_err <= 1'b1;
      end

      if ((state_nxt == LEN) || (state_nxt == DATA))
        tmr <= accept ? TMR_W'(TIMEOUT) : tmr - 1'b1;
      else
        tmr <= '0;

      if ((state == LEN) && last_byte && (word > 32'(MAX_WORDS)))
        load_err <= 1'b1;
      if ((state == LEN) && (state_nxt == DATA)) begin
        n_words   <= word;
        word_cnt  <= '0;
        next_addr <= BASE_ADDR;
        uart_addr <= BASE_ADDR;
      end

      // uart_addr only moves with a new word so it stays valid until the next write.
      if ((state == DATA) && last_byte) begin
        uart_data <= word;
        uart_we   <= 1'b1;
        uart_addr <= next_addr;
        next_addr <= next_addr + ADDR_STRIDE;
      end
      if ((state == DATA) && uart_we)
        word_cnt <= word_cnt + 32'd1;
    end
  end

endmodule

// File: doc/uart_load_ctrl.md
# uart_load_ctrl

Sequences the boot-time program load from the UART receiver into the shared memory's port B. It assembles the received byte stream into 32-bit little-endian words and issues one write per word at incrementing addresses. It raises `uart_finish` once the announced word count has been written; `uart_finish` releases the core from reset and hands port B to the MEM stage. It sits between the UART receiver and the CPU's `uart_addr` / `uart_data` / `uart_finish` inputs.

## Interface

Reset is synchronous and active-high on `clk` (one clock; `rst`).

Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first payload word.
- `MAX_WORDS`, default 16384: largest accepted word count.
- `TIMEOUT`, default 1_000_000: idle cycles allowed between bytes once a frame has started.

Ports:
- `clk`, in, 1: clock, same clock as port B of the memory.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_valid`, in, 1: one-cycle strobe meaning `rx_byte` is valid.
- `rx_byte`, in, 8: received byte.
- `uart_addr`, out, 32: port-B byte address of the current word.
- `uart_data`, out, 32: assembled word.
- `uart_we`, out, 1: one-cycle write strobe.
- `uart_finish`, out, 1: load complete; sticky until `rst`.
- `load_err`, out, 1: sticky error flag.
- `busy`, out, 1: high whenever state is not IDLE or DONE.

## Operation

- Frame format: 4 length bytes (word count N, little-endian), then 4·N payload bytes, each word little-endian (first byte → bits [7:0]).
- State machine, with transitions on `rx_valid` cycles unless stated:
  - IDLE: the first `rx_valid` captures length byte 0 and moves to LEN.
  - LEN: collects bytes 1..3. On byte 3:
    - N == 0 → DONE.
    - N > MAX_WORDS → set `load_err`, go to IDLE.
    - Otherwise → DATA, with `word_cnt` = 0 and `uart_addr` = BASE_ADDR.
  - DATA: a 2-bit `byte_idx` places each byte into a shift register.
    - On `byte_idx` == 3: register the word to `uart_data`, pulse `uart_we` the next cycle, then increment `word_cnt`.
    - `uart_addr` += 4 after each write; arithmetic is 32-bit and wraps silently.
    - When `word_cnt` reaches N after a write → DONE.
  - DONE: `uart_finish` = 1. Further `rx_valid` is ignored. Only `rst` leaves DONE.
- Timeout: a counter clears on every `rx_valid` and increments otherwise, in LEN and DATA only. On reaching TIMEOUT:
  - set `load_err`;
  - drop any partial word (no write);
  - go to IDLE, keeping already-written words in memory;
  - `uart_addr` is reloaded on the next frame.
- `rx_valid` in the same cycle as a timeout: the timeout wins and the byte is discarded.
- `rst` in any state: everything returns to reset values next cycle. A partial word is discarded and no write is issued.
- `load_err` clears only on `rst`. A later successful frame still reaches DONE with `load_err` left set.

## Timing

- Reset values:
  - state = IDLE;
  - `uart_addr` = BASE_ADDR, `uart_data` = 0;
  - `uart_we` = 0, `uart_finish` = 0, `load_err` = 0, `busy` = 0;
  - all counters 0.
- Latency:
  - Last byte of a word accepted at cycle T → `uart_we` = 1 at T+1, with `uart_addr` / `uart_data` stable from T+1 until the next write.
  - Last word's `uart_we` at T+1 → `uart_finish` = 1 at T+2.
- Back-to-back `rx_valid` on every cycle must be sustained with no byte loss, which gives at most one write every 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `uart_finish` never rises in the same cycle as any `uart_we`.

## Structure

- Shared package (`Const.svh` style) holds:
  - the `load_state_t` enum: IDLE, LEN, DATA, DONE;
  - `LOAD_LEN_BYTES` = 4;
  - the address stride constant 4.
- Single module, with no sub-module. The byte-to-word assembler is an inline shift register plus `byte_idx`.
- Top level connects:
  - `uart_addr` / `uart_data` to the CPU ports;
  - `uart_finish` directly to `CPU.uart_finish`.

## Test plan

1. Send length 2 (02 00 00 00), then bytes 13 00 00 00 93 00 10 00:
   - `uart_we` pulses 1 cycle after byte 4 and after byte 8;
   - writes are 32'h00000013 @ 0 and 32'h00100093 @ 4;
   - `uart_finish` = 1 two cycles after the last byte.
2. Send length 0 → DONE with no `uart_we` pulses, `uart_finish` = 1 one cycle after the 4th header byte.
3. Send length MAX_WORDS+1 → `load_err` = 1, state IDLE, no writes. A following valid 1-word frame completes with `uart_finish` = 1 and `load_err` still 1.
4. Send length 1 and 2 payload bytes, then idle TIMEOUT cycles → `load_err` = 1, no write, `busy` = 0. Bytes arriving afterwards are parsed as a new header.
5. Assert `rst` for 1 cycle mid-word in DATA → all outputs at reset values next cycle, no `uart_we`. Then reload a full frame and check it succeeds.
6. With `rx_valid` held high for 4+4·3 cycles (length 3) → three writes at 0, 4, 8 exactly 4 cycles apart, followed by `uart_finish`. Bytes sent after DONE produce no writes.
